spi_ram_bank: RTL and testbench
===============================

# spi_ram_bank

Parametrised single-port memory target behind the SPI slave. It decodes the 2-bit command framed on `rx_data` into write-address, write-data, read-address and read-data operations. Separate write and read address pointers auto-increment for burst transfers, and read data is returned on a valid/ready handshake. The block replaces the fixed 256x8 SPI memory and adds pointer-valid checking, overrun detection and non-power-of-two depths.

## Interface
Parameters:
- `DATA_W`, 8: memory word width and command payload width.
- `ADDR_W`, 8: address pointer width. Must satisfy ADDR_W <= DATA_W.
- `MEM_DEPTH`, 256: number of words. Must satisfy 2 <= MEM_DEPTH <= 2**ADDR_W.
- `AUTO_INC`, 1: if 1, pointers post-increment after each data access. If 0, pointers hold.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_data`, in, DATA_W+2: bits [DATA_W+1:DATA_W] are the command; bits [DATA_W-1:0] are the payload.
- `rx_valid`, in, 1: `rx_data` is valid this cycle. Each valid cycle is one command.
- `tx_data`, out, DATA_W: read data.
- `tx_valid`, out, 1: `tx_data` is valid. It holds until accepted.
- `tx_ready`, in, 1: the SPI slave accepts `tx_data`.
- `cmd_err`, out, 1: one-cycle pulse when a command is rejected.
- `ovr_err`, out, 1: one-cycle pulse when a read-data command is dropped due to back-pressure.

## Operation
The command is decoded only when `rx_valid`=1. Payload bits above ADDR_W are ignored for address commands.
- 00, load write address:
  - If payload[ADDR_W-1:0] < MEM_DEPTH: `wr_ptr` <= payload and `wr_vld` <= 1.
  - Otherwise: pulse `cmd_err`. `wr_ptr` and `wr_vld` are unchanged.
- 01, write data:
  - If `wr_vld`: mem[`wr_ptr`] <= payload.
  - If `wr_vld` and AUTO_INC: `wr_ptr` <= (`wr_ptr` == MEM_DEPTH-1) ? 0 : `wr_ptr`+1.
  - If `wr_vld`=0: pulse `cmd_err` and perform no write.
- 10, load read address: same rules as 00, applied to `rd_ptr`/`rd_vld`. Payload range checked.
- 11, read data:
  - If `rd_vld`=0: pulse `cmd_err`.
  - Else if the output slot is occupied (`tx_valid` && !`tx_ready`): pulse `ovr_err`. The command is dropped and `rd_ptr` is unchanged.
  - Else: `tx_data` <= mem[`rd_ptr`], `tx_valid` <= 1, and `rd_ptr` post-increments with wrap if AUTO_INC.
- Output slot: `tx_valid` clears on the cycle after `tx_valid`&&`tx_ready`, unless a read-data command is accepted in that same cycle. In that case `tx_valid` stays 1 and `tx_data` takes the new word.
- Write and read pointers are independent. Loading one never affects the other.
- Memory contents are not reset and are X until written. Pointers and flags are reset.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `cmd_err`=0, `ovr_err`=0. Internal state `wr_ptr`=0, `rd_ptr`=0, `wr_vld`=0, `rd_vld`=0.
- Reset mid-transfer: a pending `tx_valid` drops on the reset edge. Memory is untouched.
- Read latency: a read-data command sampled at edge N gives `tx_data`/`tx_valid` valid after edge N.
- Throughput: one command per cycle sustained, including back-to-back reads while `tx_ready`=1.
- Write-to-read: a write at edge N is visible to a read-data command sampled at edge N+1.
- A read of the address written in the same cycle is impossible, because there is one command per cycle.
- Error pulses: asserted for exactly the cycle after the offending command edge, then 0.
- `rx_valid`=0: no state change except handshake retirement of `tx_valid`.

## Test plan
- Burst write and read-back:
  - Stimulus: cmd 00 with 0x10, then cmd 01 with 0xA1, 0xB2, 0xC3; cmd 10 with 0x10, then three cmd 11 with `tx_ready`=1.
  - Required: `tx_data` = 0xA1, 0xB2, 0xC3 on consecutive cycles and `tx_valid` high for 3 cycles.
- Wrap at non-power-of-two depth:
  - Stimulus: MEM_DEPTH=200. Write address 199, write 0x55 then 0x66; read back from 199, two reads.
  - Required: read data 0x55 then 0x66, with mem[0]=0x66. A load-address command with 200 pulses `cmd_err` and the pointer is unchanged.
- Pointer-valid checks:
  - Stimulus: after reset, cmd 01 with 0x77, then cmd 11.
  - Required: `cmd_err` pulses twice, no memory write, `tx_valid` stays 0.
- Back-pressure and overrun:
  - Stimulus: read with `tx_ready`=0, then a second read.
  - Required: `ovr_err` pulses, `tx_data` keeps the first word and `rd_ptr` advances by only 1. Raising `tx_ready` clears `tx_valid` on the next cycle.
- AUTO_INC=0:
  - Stimulus: two writes 0x11, 0x22 after address 0x05; two reads from 0x05.
  - Required: both reads return 0x22.
- Reset mid-transfer:
  - Stimulus: assert `rst` while `tx_valid`=1.
  - Required: `tx_valid`=0 next cycle and the next cmd 11 pulses `cmd_err`. Previously written data is readable again after reloading the address.

Source files
------------

// File: rtl/spi_ram_bank_if.sv
// Command/response bus between the SPI slave (master side) and the memory target (slave side).
interface spi_ram_bank_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              cmd_err;
  logic              ovr_err;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, cmd_err, ovr_err
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, cmd_err, ovr_err
  );
endinterface

// File: rtl/spi_ram_bank.sv
// Parametrised single-port memory target behind the SPI slave.
// Decodes 2-bit commands into write/read address loads and data accesses,
// with independent auto-incrementing pointers and a one-entry output slot.
module spi_ram_bank #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic          clk,
  input  logic          rst,
  spi_ram_bank_if.slave bus
);

  typedef enum logic [1:0] {
    CMD_WADDR = 2'b00,
    CMD_WDATA = 2'b01,
    CMD_RADDR = 2'b10,
    CMD_RDATA = 2'b11
  } cmd_e;

  localparam int                IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              wr_vld_q, wr_vld_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              cmd_err_q, cmd_err_d;
  logic              ovr_err_q, ovr_err_d;

  cmd_e              cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr_in;
  logic              addr_ok;
  logic              slot_free;
  logic              rd_take;
  logic              mem_we;

  // Post-increment with wrap at the last implemented word; holds when auto-increment is off.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    if (AUTO_INC == 0)
      return p;
    else if (p == LAST)
      return '0;
    else
      return p + ADDR_W'(1);
  endfunction

  // Field split and address range check of the incoming command.
  always_comb begin
    cmd       = cmd_e'(bus.rx_data[DATA_W+1:DATA_W]);
    payload   = bus.rx_data[DATA_W-1:0];
    addr_in   = payload[ADDR_W-1:0];
    addr_ok   = ({1'b0, addr_in} < DEPTH_V);
    slot_free = !tx_valid_q || bus.tx_ready;
  end

  // Command decode, pointer updates, error pulses and output slot next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_vld_d   = wr_vld_q;
    rd_vld_d   = rd_vld_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    cmd_err_d  = 1'b0;
    ovr_err_d  = 1'b0;
    mem_we     = 1'b0;
    rd_take    = 1'b0;

    if (bus.rx_valid) begin
      unique case (cmd)
        CMD_WADDR: begin
          if (addr_ok) begin
            wr_ptr_d = addr_in;
            wr_vld_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_WDATA: begin
          if (wr_vld_q) begin
            mem_we   = 1'b1;
            wr_ptr_d = ptr_next(wr_ptr_q);
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RADDR: begin
          if (addr_ok) begin
            rd_ptr_d = addr_in;
            rd_vld_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        CMD_RDATA: begin
          if (!rd_vld_q) begin
            cmd_err_d = 1'b1;
          end else if (!slot_free) begin
            ovr_err_d = 1'b1;
          end else begin
            rd_take  = 1'b1;
            rd_ptr_d = ptr_next(rd_ptr_q);
          end
        end
      endcase
    end

    // A new word refills the slot in the same cycle the old one retires.
    if (rd_take) begin
      tx_data_d  = mem[rd_ptr_q[IDX_W-1:0]];
      tx_valid_d = 1'b1;
    end else if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_vld_q   <= wr_vld_d;
      rd_vld_q   <= rd_vld_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  // Memory array: not reset; writes suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem[wr_ptr_q[IDX_W-1:0]] <= payload;
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.cmd_err  = cmd_err_q;
  assign bus.ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_spi_ram_bank.sv
// Self-checking bench: three instances (256/inc, 200/inc, 256/no-inc) share one
// command stream and are compared every cycle against a behavioural model.
module tb_spi_ram_bank;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_r = 1'b1;
  logic       d_valid = 1'b0;
  logic [1:0] d_cmd = 2'b00;
  logic [7:0] d_pay = 8'h00;
  logic       d_rdy = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_ram_bank_if #(.DATA_W(8)) bus0 ();
  spi_ram_bank_if #(.DATA_W(8)) bus1 ();
  spi_ram_bank_if #(.DATA_W(8)) bus2 ();

  spi_ram_bank #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1))
    dut0 (.clk(clk), .rst(rst_r), .bus(bus0));
  spi_ram_bank #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1))
    dut1 (.clk(clk), .rst(rst_r), .bus(bus1));
  spi_ram_bank #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0))
    dut2 (.clk(clk), .rst(rst_r), .bus(bus2));

  assign bus0.rx_data = {d_cmd, d_pay};
  assign bus1.rx_data = {d_cmd, d_pay};
  assign bus2.rx_data = {d_cmd, d_pay};
  assign bus0.rx_valid = d_valid;
  assign bus1.rx_valid = d_valid;
  assign bus2.rx_valid = d_valid;
  assign bus0.tx_ready = d_rdy;
  assign bus1.tx_ready = d_rdy;
  assign bus2.tx_ready = d_rdy;

  logic [7:0] o_txd  [N];
  logic       o_txv  [N];
  logic       o_cerr [N];
  logic       o_oerr [N];

  assign o_txd[0] = bus0.tx_data;  assign o_txv[0] = bus0.tx_valid;
  assign o_txd[1] = bus1.tx_data;  assign o_txv[1] = bus1.tx_valid;
  assign o_txd[2] = bus2.tx_data;  assign o_txv[2] = bus2.tx_valid;
  assign o_cerr[0] = bus0.cmd_err; assign o_oerr[0] = bus0.ovr_err;
  assign o_cerr[1] = bus1.cmd_err; assign o_oerr[1] = bus1.ovr_err;
  assign o_cerr[2] = bus2.cmd_err; assign o_oerr[2] = bus2.ovr_err;

  // Reference model state, one set per instance.
  int unsigned m_depth [N] = '{256, 200, 256};
  bit          m_inc   [N] = '{1'b1, 1'b1, 1'b0};
  int unsigned m_mem   [N][256];
  int unsigned m_wp [N], m_rp [N];
  bit          m_wv [N], m_rv [N];
  int unsigned m_txd [N];
  bit          m_txv [N], m_cerr [N], m_oerr [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge worth of commands to the model.
  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      bit took;
      took      = 1'b0;
      m_cerr[i] = 1'b0;
      m_oerr[i] = 1'b0;
      if (rst_r) begin
        m_wp[i] = 0; m_rp[i] = 0; m_wv[i] = 0; m_rv[i] = 0;
        m_txd[i] = 0; m_txv[i] = 0;
      end else begin
        if (d_valid) begin
          case (d_cmd)
            2'b00: if (d_pay < m_depth[i]) begin m_wp[i] = d_pay; m_wv[i] = 1; end
                   else m_cerr[i] = 1;
            2'b01: if (m_wv[i]) begin
                     m_mem[i][m_wp[i]] = d_pay;
                     if (m_inc[i]) m_wp[i] = (m_wp[i] + 1) % m_depth[i];
                   end else m_cerr[i] = 1;
            2'b10: if (d_pay < m_depth[i]) begin m_rp[i] = d_pay; m_rv[i] = 1; end
                   else m_cerr[i] = 1;
            default: begin
              if (!m_rv[i]) m_cerr[i] = 1;
              else if (m_txv[i] && !d_rdy) m_oerr[i] = 1;
              else begin
                m_txd[i] = m_mem[i][m_rp[i]];
                took = 1'b1;
                if (m_inc[i]) m_rp[i] = (m_rp[i] + 1) % m_depth[i];
              end
            end
          endcase
        end
        if (took) m_txv[i] = 1;
        else if (m_txv[i] && d_rdy) m_txv[i] = 0;
      end
    end
  endtask

  // Drive one cycle (called just after a falling edge), then compare all instances.
  task automatic step(input logic v, input logic [1:0] c, input logic [7:0] p);
    d_valid = v; d_cmd = c; d_pay = p;
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("tx_valid[%0d]", i), 32'(o_txv[i]),  32'(m_txv[i]));
      check($sformatf("tx_data[%0d]", i),  32'(o_txd[i]),  m_txd[i]);
      check($sformatf("cmd_err[%0d]", i),  32'(o_cerr[i]), 32'(m_cerr[i]));
      check($sformatf("ovr_err[%0d]", i),  32'(o_oerr[i]), 32'(m_oerr[i]));
    end
    @(negedge clk);
  endtask

  task automatic cmd(input logic [1:0] c, input logic [7:0] p);
    step(1'b1, c, p);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 8'h00);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Reset state
    rst_r = 1'b1;
    idle();
    idle();
    rst_r = 1'b0;

    // Pointer-valid checks: both commands rejected right after reset
    d_rdy = 1'b1;
    cmd(2'b01, 8'h77);
    check("ptr_vld_wr_err", 32'(o_cerr[0]), 32'd1);
    cmd(2'b11, 8'h00);
    check("ptr_vld_rd_err", 32'(o_cerr[0]), 32'd1);
    check("ptr_vld_no_tx", 32'(o_txv[0]), 32'd0);
    idle();

    // Define every word so later reads never see uninitialised memory
    for (int a = 0; a < 256; a++) begin
      cmd(2'b00, 8'(a));
      cmd(2'b01, 8'($urandom_range(255)));
    end

    // Burst write and read-back
    cmd(2'b00, 8'h10);
    cmd(2'b01, 8'hA1);
    cmd(2'b01, 8'hB2);
    cmd(2'b01, 8'hC3);
    cmd(2'b10, 8'h10);
    cmd(2'b11, 8'h00); check("burst_rd0", 32'(o_txd[0]), 32'hA1);
    cmd(2'b11, 8'h00); check("burst_rd1", 32'(o_txd[0]), 32'hB2);
    cmd(2'b11, 8'h00); check("burst_rd2", 32'(o_txd[0]), 32'hC3);
    check("burst_vld", 32'(o_txv[0]), 32'd1);
    idle();
    check("burst_done", 32'(o_txv[0]), 32'd0);

    // Wrap at depth 200 (instance 1)
    cmd(2'b00, 8'd199);
    cmd(2'b01, 8'h55);
    cmd(2'b01, 8'h66);
    cmd(2'b10, 8'd199);
    cmd(2'b11, 8'h00); check("wrap_rd0", 32'(o_txd[1]), 32'h55);
    cmd(2'b11, 8'h00); check("wrap_rd1", 32'(o_txd[1]), 32'h66);
    cmd(2'b10, 8'd0);
    cmd(2'b11, 8'h00); check("wrap_mem0", 32'(o_txd[1]), 32'h66);
    cmd(2'b00, 8'd200); check("wrap_oob_err", 32'(o_cerr[1]), 32'd1);
    cmd(2'b10, 8'd200); check("wrap_oob_rerr", 32'(o_cerr[1]), 32'd1);
    cmd(2'b01, 8'h99);
    cmd(2'b11, 8'h00);
    idle();

    // Back-pressure and overrun
    d_rdy = 1'b0;
    cmd(2'b10, 8'h20);
    cmd(2'b11, 8'h00);
    cmd(2'b11, 8'h00); check("ovr_pulse", 32'(o_oerr[0]), 32'd1);
    idle();            check("ovr_once", 32'(o_oerr[0]), 32'd0);
    check("ovr_hold", 32'(o_txv[0]), 32'd1);
    d_rdy = 1'b1;
    idle();            check("ovr_retire", 32'(o_txv[0]), 32'd0);
    cmd(2'b11, 8'h00);
    idle();

    // AUTO_INC=0 (instance 2)
    cmd(2'b00, 8'h05);
    cmd(2'b01, 8'h11);
    cmd(2'b01, 8'h22);
    cmd(2'b10, 8'h05);
    cmd(2'b11, 8'h00); check("noinc_rd0", 32'(o_txd[2]), 32'h22);
    cmd(2'b11, 8'h00); check("noinc_rd1", 32'(o_txd[2]), 32'h22);
    idle();

    // Reset mid-transfer
    d_rdy = 1'b0;
    cmd(2'b10, 8'h10);
    cmd(2'b11, 8'h00);
    rst_r = 1'b1;
    idle();            check("rst_drop", 32'(o_txv[0]), 32'd0);
    rst_r = 1'b0;
    d_rdy = 1'b1;
    cmd(2'b11, 8'h00); check("rst_rd_err", 32'(o_cerr[0]), 32'd1);
    cmd(2'b10, 8'h10);
    cmd(2'b11, 8'h00); check("rst_mem_kept", 32'(o_txd[0]), 32'hA1);
    idle();

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      d_rdy = ($urandom_range(99) < 60);
      rst_r = ($urandom_range(599) == 0);
      r = $urandom_range(99);
      if (r < 15) idle();
      else        cmd(2'($urandom_range(3)), 8'($urandom_range(255)));
    end
    rst_r = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
